// File: rtl/pi_loop_filter.sv
// ============================================================================
// Module      : pi_loop_filter
// Description : Proportional-integral loop filter for a bang-bang phase
//               detector. It steers an oscillator control word, with
//               saturating arithmetic and an optional ACQ/TRACK lock
//               detector that switches between two gain sets.
//               Optional feature macro: PI_LF_LOCK_DET_EN (lock FSM in/out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pi_loop_filter #(
  parameter int W        = 24,
  parameter int KP_ACQ   = 64,
  parameter int KP_TRK   = 8,
  parameter int KI_ACQ   = 4,
  parameter int KI_TRK   = 1,
  parameter int LOCK_CNT = 256,
  parameter int RUN_MAX  = 4,
  parameter int LOSS_RUN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ctrl_out,
  output logic [W-1:0] integ_out,
  output logic         locked,
  output logic         sat
);

  // Two guard bits: one for the sign, one for carry above 2^W-1.
  localparam int c_ext_w = W + 2;

  localparam logic [W-1:0] c_mid = {1'b1, {(W-1){1'b0}}};

  localparam logic signed [c_ext_w-1:0] c_ki_acq = c_ext_w'(KI_ACQ);
  localparam logic signed [c_ext_w-1:0] c_ki_trk = c_ext_w'(KI_TRK);
  localparam logic signed [c_ext_w-1:0] c_kp_acq = c_ext_w'(KP_ACQ);
  localparam logic signed [c_ext_w-1:0] c_kp_trk = c_ext_w'(KP_TRK);

  // Reject parameter sets the datapath and counters cannot represent.
  if (W < 8 || W > 32 || LOCK_CNT < 1 || RUN_MAX < 1 || LOSS_RUN < RUN_MAX ||
      KP_ACQ < 0 || KP_TRK < 0 || KI_ACQ < 0 || KI_TRK < 0) begin : g_param_err
    $error("pi_loop_filter: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // Error decode: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0 (both or neither asserted)
  // --------------------------------------------------------------------------
  logic       w_err_pos;
  logic       w_err_neg;
  logic [1:0] w_err;

  assign w_err_pos = up & ~dn;
  assign w_err_neg = dn & ~up;
  assign w_err     = w_err_pos ? 2'b01 : (w_err_neg ? 2'b11 : 2'b00);

  // Gain set selection; the lock detector drives w_trk when it is built in.
  logic w_trk;

  // --------------------------------------------------------------------------
  // Saturating datapath
  // --------------------------------------------------------------------------
  logic signed [c_ext_w-1:0] w_ki;
  logic signed [c_ext_w-1:0] w_kp;
  logic signed [c_ext_w-1:0] w_step_i;
  logic signed [c_ext_w-1:0] w_step_p;
  logic signed [c_ext_w-1:0] w_sum_i;
  logic signed [c_ext_w-1:0] w_sum_p;
  logic [W-1:0]              w_integ_new;
  logic [W-1:0]              w_ctrl_new;
  logic                      w_sat;

  logic [W-1:0] r_integ;
  logic [W-1:0] r_ctrl;
  logic         r_sat;

  // Clamp an extended signed value into [0, 2^W-1].
  function automatic logic [W-1:0] f_clamp(input logic signed [c_ext_w-1:0] v);
    if (v[c_ext_w-1])
      return '0;
    else if (|v[c_ext_w-2:W])
      return '1;
    else
      return v[W-1:0];
  endfunction

  // True when clamping changes the value (negative or above 2^W-1).
  function automatic logic f_out_of_range(input logic signed [c_ext_w-1:0] v);
    return v[c_ext_w-1] | (|v[c_ext_w-2:W]);
  endfunction

  assign w_ki     = w_trk ? c_ki_trk : c_ki_acq;
  assign w_kp     = w_trk ? c_kp_trk : c_kp_acq;
  assign w_step_i = w_err_pos ? w_ki : (w_err_neg ? -w_ki : '0);
  assign w_step_p = w_err_pos ? w_kp : (w_err_neg ? -w_kp : '0);

  // Proportional term rides on the already-updated integrator value.
  assign w_sum_i     = signed'({2'b00, r_integ}) + w_step_i;
  assign w_integ_new = f_clamp(w_sum_i);
  assign w_sat       = f_out_of_range(w_sum_i);
  assign w_sum_p     = signed'({2'b00, w_integ_new}) + w_step_p;
  assign w_ctrl_new  = f_clamp(w_sum_p);

  // Integrator, control word and saturation flag; load overrides a sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_integ <= c_mid;
      r_ctrl  <= c_mid;
      r_sat   <= 1'b0;
    end else if (load) begin
      r_integ <= load_val;
      r_ctrl  <= load_val;
      r_sat   <= 1'b0;
    end else if (en) begin
      r_integ <= w_integ_new;
      r_ctrl  <= w_ctrl_new;
      r_sat   <= w_sat;
    end
  end

  assign integ_out = r_integ;
  assign ctrl_out  = r_ctrl;
  assign sat       = r_sat;

`ifdef PI_LF_LOCK_DET_EN
  // --------------------------------------------------------------------------
  // Lock detector: counts well-behaved samples in ACQ, watches for long
  // same-sign runs (a sign of lost lock) in TRACK.
  // --------------------------------------------------------------------------
  localparam int c_run_w = $clog2(LOSS_RUN + 1);
  localparam int c_q_w   = $clog2(LOCK_CNT + 1);

  localparam logic [c_run_w-1:0] c_run_max  = c_run_w'(RUN_MAX);
  localparam logic [c_run_w-1:0] c_loss_run = c_run_w'(LOSS_RUN);
  localparam logic [c_q_w-1:0]   c_q_last   = c_q_w'(LOCK_CNT - 1);

  typedef enum logic [0:0] {
    S_ACQ   = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_locked;
  logic [c_q_w-1:0]   r_qcnt;
  logic [c_run_w-1:0] r_run;
  logic [1:0]         r_sign;
  logic [c_run_w-1:0] w_run_new;

  assign w_trk = (r_state == S_TRACK);

  // Run length after the current sample; a first or sign-flipping error restarts at 1.
  always_comb begin
    w_run_new = r_run;
    if (w_err != 2'b00) begin
      if (w_err == r_sign)
        w_run_new = (r_run >= c_loss_run) ? r_run : r_run + 1'b1;
      else
        w_run_new = c_run_w'(1);
    end
  end

  // ACQ/TRACK state machine with run/qualification counters and registered lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_ACQ;
      r_locked <= 1'b0;
      r_qcnt   <= '0;
      r_run    <= '0;
      r_sign   <= 2'b00;
    end else if (load) begin
      r_state  <= S_ACQ;
      r_locked <= 1'b0;
      r_qcnt   <= '0;
      r_run    <= '0;
      r_sign   <= 2'b00;
    end else if (en) begin
      r_run <= w_run_new;
      if (w_err != 2'b00)
        r_sign <= w_err;
      case (r_state)
        S_ACQ: begin
          if (w_run_new < c_run_max) begin
            if (r_qcnt == c_q_last) begin
              r_state  <= S_TRACK;
              r_locked <= 1'b1;
              r_qcnt   <= '0;
            end else begin
              r_qcnt <= r_qcnt + 1'b1;
            end
          end else begin
            r_qcnt <= '0;
          end
        end
        S_TRACK: begin
          if (w_run_new >= c_loss_run) begin
            r_state  <= S_ACQ;
            r_locked <= 1'b0;
            r_qcnt   <= '0;
          end
        end
        default: begin
          r_state  <= S_ACQ;
          r_locked <= 1'b0;
          r_qcnt   <= '0;
        end
      endcase
    end
  end

  assign locked = r_locked;
`else
  // Lock detector compiled out: acquisition gains always apply.
  assign w_trk  = 1'b0;
  assign locked = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pi_loop_filter.sv
// ============================================================================
// Module      : tb_pi_loop_filter
// Description : Directed self-checking bench for pi_loop_filter (W=24,
//               default gains). Lock-related expectations follow
//               PI_LF_LOCK_DET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pi_loop_filter;

  localparam int W = 24;
  localparam int M = 8388608;
  localparam int MAXV = 16777215;

`ifdef PI_LF_LOCK_DET_EN
  localparam int KI_T   = 1;
  localparam int KP_T   = 8;
  localparam int LOCK_E = 1;
`else
  localparam int KI_T   = 4;
  localparam int KP_T   = 64;
  localparam int LOCK_E = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up;
  logic         dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] ctrl_out;
  logic [W-1:0] integ_out;
  logic         locked;
  logic         sat;

  int n_checks = 0;
  int n_errors = 0;

  pi_loop_filter #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .dn       (dn),
    .load     (load),
    .load_val (load_val),
    .ctrl_out (ctrl_out),
    .integ_out(integ_out),
    .locked   (locked),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic samp(input logic u, input logic d);
    up = u; dn = d; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Alternating samples beginning with up.
  task automatic alt(input int n);
    for (int i = 0; i < n; i++) samp((i % 2) == 0, (i % 2) != 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0; load = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_integ", integ_out, M);
    chk("rst_ctrl", ctrl_out, M);
    chk("rst_locked", locked, 0);
    chk("rst_sat", sat, 0);
    rst = 1'b0;
    idle(1);

    // One up sample from reset.
    samp(1, 0);
    chk("up1_integ", integ_out, M + 4);
    chk("up1_ctrl", ctrl_out, M + 68);
    chk("up1_sat", sat, 0);

    // en=0 holds everything even with up asserted.
    up = 1'b1; dn = 1'b0;
    idle(3);
    chk("hold_integ", integ_out, M + 4);
    chk("hold_ctrl", ctrl_out, M + 68);

    // One down sample.
    samp(0, 1);
    chk("dn1_integ", integ_out, M);
    chk("dn1_ctrl", ctrl_out, M - 64);

    // Upper clamp.
    do_load(24'd16777214);
    chk("ldhi_integ", integ_out, 16777214);
    chk("ldhi_ctrl", ctrl_out, 16777214);
    chk("ldhi_sat", sat, 0);
    samp(1, 0);
    chk("hi1_integ", integ_out, MAXV);
    chk("hi1_ctrl", ctrl_out, MAXV);
    chk("hi1_sat", sat, 1);
    samp(1, 0);
    chk("hi2_integ", integ_out, MAXV);
    chk("hi2_ctrl", ctrl_out, MAXV);
    chk("hi2_sat", sat, 1);

    // Lower clamp, then zero error clears sat.
    do_load(24'd2);
    samp(0, 1);
    chk("lo_integ", integ_out, 0);
    chk("lo_ctrl", ctrl_out, 0);
    chk("lo_sat", sat, 1);
    samp(1, 1);
    chk("zero_integ", integ_out, 0);
    chk("zero_ctrl", ctrl_out, 0);
    chk("zero_sat", sat, 0);

    // Load wins over a simultaneous en sample.
    load = 1'b1; load_val = 24'd1000; en = 1'b1; up = 1'b1; dn = 1'b0;
    @(posedge clk); #1;
    load = 1'b0; en = 1'b0;
    chk("ldpri_integ", integ_out, 1000);
    chk("ldpri_ctrl", ctrl_out, 1000);

    // Lock acquisition with alternating samples.
    do_load(W'(M));
    alt(255);
    chk("lock255", locked, 0);
    samp(0, 1);
    chk("lock256", locked, LOCK_E);
    chk("lock256_integ", integ_out, M);
    samp(1, 0);
    chk("trk1_integ", integ_out, M + KI_T);
    chk("trk1_ctrl", ctrl_out, M + KI_T + KP_T);

    // Same-sign run with an en=0 gap inside.
    repeat (4) samp(1, 0);
    up = 1'b1; dn = 1'b0;
    idle(3);
    chk("gap_integ", integ_out, M + 5 * KI_T);
    repeat (10) samp(1, 0);
    chk("run15_locked", locked, LOCK_E);
    chk("run15_integ", integ_out, M + 15 * KI_T);
    samp(1, 0);
    chk("run16_locked", locked, 0);
    chk("run16_integ", integ_out, M + 16 * KI_T);
    chk("run16_ctrl", ctrl_out, M + 16 * KI_T + KP_T);
    samp(1, 0);
    chk("acq_again_integ", integ_out, M + 16 * KI_T + 4);
    chk("acq_again_ctrl", ctrl_out, M + 16 * KI_T + 68);

    // Asynchronous reset mid-acquisition, then a full re-lock.
    do_load(W'(M));
    alt(100);
    chk("pre_rst_ctrl", ctrl_out, M - 64);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_integ", integ_out, M);
    chk("arst_ctrl", ctrl_out, M);
    chk("arst_locked", locked, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    alt(255);
    chk("relock255", locked, 0);
    samp(0, 1);
    chk("relock256", locked, LOCK_E);
    chk("relock_integ", integ_out, M);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pi_loop_filter.md
PI_LOOP_FILTER -- requirements
Module: pi_loop_filter

Interface
REQ-001 SHALL have parameter W, default 24: control word width, 8..32.
REQ-002 SHALL have parameter KP_ACQ, default 64: proportional magnitude in ACQ.
REQ-003 SHALL have parameter KP_TRK, default 8: proportional magnitude in TRACK.
REQ-004 SHALL have parameter KI_ACQ, default 4: integrator step in ACQ.
REQ-005 SHALL have parameter KI_TRK, default 1: integrator step in TRACK.
REQ-006 SHALL have parameter LOCK_CNT, default 256: qualifying samples to lock.
REQ-007 SHALL have parameter RUN_MAX, default 4: same-sign run that disqualifies a sample.
REQ-008 SHALL have parameter LOSS_RUN, default 16: same-sign run that drops lock.
REQ-009 SHALL have ports, in order:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  sample qualifier
- up  in  1  phase-detector up
- dn  in  1  phase-detector down
- load  in  1  preset strobe
- load_val  in  W  preset value
- ctrl_out  out  W  oscillator control word
- integ_out  out  W  integrator state
- locked  out  1  TRACK indicator
- sat  out  1  integrator clamped this sample
REQ-010 SHALL use reset rst, asynchronous, active-high, and clock clk.

Function
REQ-011 SHALL decode err = +1 for up&~dn, -1 for dn&~up, 0 for 00 or 11.
REQ-012 SHALL, on an en=1 cycle without load, set integ to clamp(integ + err*KI), with KI from the current state.
REQ-013 SHALL register ctrl_out = clamp(new integ + err*KP) on the same edge, giving 1-cycle latency from up/dn to ctrl_out.
REQ-014 SHALL clamp to [0, 2^W-1], using internal arithmetic of at least W+2 signed bits so the sum never wraps.
REQ-015 SHALL register sat=1 when the integrator clamp altered the sum and sat=0 otherwise; sat updates only on en or load cycles.
REQ-016 SHALL hold all state and outputs on en=0 cycles.
REQ-017 SHALL give load priority over en: integ<=load_val, ctrl_out<=load_val, sat<=0, state<=ACQ, counters and sign<=0.
REQ-018 SHALL track run length on en cycles:
- same nonzero sign as the last nonzero err: run+1, saturating at LOSS_RUN;
- opposite nonzero sign: run=1;
- err=0: run unchanged.
REQ-019 SHALL use FSM states ACQ and TRACK, with locked registered as state==TRACK.
REQ-020 SHALL, in ACQ, increment qcnt on en cycles whose updated run < RUN_MAX and clear it otherwise; reaching LOCK_CNT moves to TRACK and clears qcnt.
REQ-021 SHALL, in TRACK, return to ACQ when the updated run reaches LOSS_RUN.
REQ-022 SHALL take new gains effective from the sample after the state change.

Reset
REQ-023 SHALL on reset set integ and ctrl_out to 2^(W-1), integ_out to 2^(W-1), and set state=ACQ, locked=0, sat=0, qcnt=0, run=0, last sign=0.
REQ-024 SHALL abort any run or lock count on reset asserted mid-operation, with no residual state.

Configuration
REQ-025 SHALL use macro PI_LF_LOCK_DET_EN to compile the lock FSM in or out.
- Defined: REQ-018..022 apply.
- Undefined: no FSM or counters; locked is constant 0; KP_ACQ and KI_ACQ are always used.

Verification (W=24, defaults)
REQ-026 SHALL cover: reset, then one en cycle up=1 -> integ_out=8388612, ctrl_out=8388676, sat=0.
REQ-027 SHALL cover: load 16777214, then up for 2 en cycles -> integ_out=16777215, ctrl_out=16777215, sat=1 on 2nd.
REQ-028 SHALL cover: load 2, then dn one cycle -> integ_out=0, ctrl_out=0, sat=1; then up=dn=1 -> integ_out=0, ctrl_out=0, sat=0.
REQ-029 SHALL cover: alternating up/dn for 256 en cycles -> locked=1 after 256th edge; next up sample -> integ +1, ctrl_out = integ+8.
REQ-030 SHALL cover: in TRACK, 16 consecutive up samples -> locked=0 after 16th; en=0 gaps inside the run leave run unchanged.
REQ-031 SHALL cover: rst pulse after 100 alternating samples -> outputs 8388608, locked=0, and re-lock requires a full 256 samples.
